cb_seg_ingress_arb: RTL and testbench
=====================================

# cb_seg_ingress_arb

Two-port ingress arbiter in front of `cb_seg`. It shares the segmenter's single transport-block input (the size-write port plus the serial data-write port) between two transfer-layer requesters. Whole TBs are granted round-robin, one at a time. Each TB is delivered as one size write followed by exactly `size` data-bit writes, so size and data entries in the segmenter's FIFOs always pair up.

## Interface
Parameters
- `TB_SIZE_W`, 16, width of the TB size field; matches `tb_size_in`.

Ports
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  2  per-requester TB request; must be held, with `size0`/`size1` stable, until `gnt[i]` or `err[i]`.
- `size0`, `size1`  in  16  TB length in bits for requester 0/1.
- `data_in`  in  2  serial TB bit per requester.
- `data_valid`  in  2  `data_in[i]` is valid this cycle.
- `seg_ready`  in  1  segmenter may accept a new TB; sampled only at arbitration.
- `gnt`  out  2  one-hot grant, held from the SIZE state through the DONE state.
- `data_ready`  out  2  requester `i` may present bits (granted, state DATA).
- `done`  out  2  1-cycle pulse when the last bit of requester `i`'s TB is written.
- `err`  out  2  1-cycle pulse when a zero-size request is rejected.
- `tb_in`  out  1  to `cb_seg.tb_in`.
- `wreq_data`  out  1  to `cb_seg.wreq_data`.
- `tb_size_in`  out  16  to `cb_seg.tb_size_in`.
- `wreq_size`  out  1  to `cb_seg.wreq_size`.

## Operation
- States:
  - IDLE → SIZE when a winning request has nonzero size and `seg_ready` is high.
  - SIZE → DATA unconditionally.
  - DATA → DONE when the last bit is accepted.
  - DONE → IDLE unconditionally.
- Arbitration happens in IDLE only, using a 1-bit round-robin pointer `rr`:
  - `rr` is 0 after reset.
  - With both requests pending, the requester indexed by `rr` wins.
  - With one request pending, that requester wins.
  - `rr` becomes ~winner whenever a grant or a rejection is issued.
- Zero-size reject: if the winner's size is 0, pulse `err[winner]` the next cycle, issue no writes, advance `rr`, and stay in IDLE. This check ignores `seg_ready`.
- The winner's size is latched into a 16-bit remaining-bit counter at the grant.
- DATA state:
  - A bit is accepted when `data_ready[g] & data_valid[g]`; the counter decrements per accepted bit.
  - The bit is forwarded as `tb_in`/`wreq_data`.
  - Gaps in `data_valid` hold the counter.
- Non-granted requesters' `data_valid`/`data_in` are ignored.
- A change on `req` after grant has no effect; the grant persists until DONE.
- Counter arithmetic is unsigned 16-bit. The last bit is the one accepted while count == 1. Size 65535 is legal, and the counter never wraps.

## Timing
- Reset values: `gnt`=0, `data_ready`=0, `done`=0, `err`=0, `tb_in`=0, `wreq_data`=0, `wreq_size`=0, `tb_size_in`=0, state IDLE, `rr`=0, counter 0.
- Request seen in IDLE at cycle t leads to:
  - t+1: state SIZE; `gnt` high; `wreq_size`=1 for that single cycle; `tb_size_in`=latched size.
  - t+2: state DATA; `data_ready` high.
- Output write latency is 1 cycle: a bit accepted at cycle d gives `wreq_data`=1 and `tb_in`=bit at d+1.
- Last bit accepted at cycle L:
  - L+1: state DONE, `done[g]` pulses, final `wreq_data`; `data_ready` goes low at L+1.
  - L+2: IDLE with `gnt`=0.
  - Next grant earliest at L+3.
- `tb_size_in` holds its value between size writes.
- Reset asserted in any state, including mid-DATA: all outputs take their reset values on the next edge and the partial TB is abandoned. Flushing the segmenter's FIFOs is the system's job; `cb_seg` shares the same reset.

## Structure
- Package `cb_seg_pkg`: `TB_SIZE_W`; state enum `ingress_state_t` {IDLE, SIZE, DATA, DONE}.
- One sub-module: `rr_arb2`, a 2-requester round-robin picker that takes `req`, `rr` and an `adv` strobe and returns a one-hot `win`. The FSM, counter and output registers live in the top.

## Test plan
- Single TB: req0, size0=5, bits 1,0,1,1,0 presented back-to-back → `wreq_size` once with 5; five `wreq_data` pulses carrying 1,0,1,1,0; `done[0]` once; `gnt` low at L+2.
- Contention: after reset, req0 and req1 held together (size 3 each) → TB0 fully precedes TB1. A second simultaneous pair → requester 0 wins again, because `rr` was set to 0 after requester 1's grant.
- Valid gaps: size 4, `data_valid` toggling 1,0,0,1,1,0,1 → exactly 4 `wreq_data`; counter held during gaps; `done` follows the 4th bit.
- Backpressure: req1 with `seg_ready`=0 for 10 cycles → no `gnt`/`wreq_size`; grant at t+1 after `seg_ready` rises.
- Zero size: req0 with size0=0 → `err[0]` one cycle later; no writes; a pending req1 (size 2) is granted next.
- Reset mid-DATA: size 100, reset at bit 40 → all outputs 0 the next cycle. A new TB of size 2 then completes with exactly 2 data writes.

Source files
------------

// File: rtl/cb_seg_pkg.sv
// Shared types and constants for the cb_seg transport-block ingress path.
package cb_seg_pkg;

  localparam int TB_SIZE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SIZE = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } ingress_state_t;

  // One-hot encoding of a 1-bit requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cb_seg_ingress_arb_rr_arb2.sv
// Two-requester round-robin picker: rr names the favoured requester when both
// request; the output is one-hot and forced to zero when adv is low.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       adv,
  output logic [1:0] win
);

  // Pick the winner among the pending requests.
  always_comb begin
    win = 2'b00;
    if (adv) begin
      case (req)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = rr ? 2'b10 : 2'b01;
        default: win = 2'b00;
      endcase
    end else begin
      win = 2'b00;
    end
  end

endmodule

// File: rtl/cb_seg_ingress_arb.sv
// Two-port ingress arbiter in front of cb_seg. Whole transport blocks are
// granted round-robin; each is delivered as one size write followed by
// exactly `size` serial data writes. All outputs are registered.
module cb_seg_ingress_arb #(
  parameter int TB_SIZE_W = cb_seg_pkg::TB_SIZE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [TB_SIZE_W-1:0] size0,
  input  logic [TB_SIZE_W-1:0] size1,
  input  logic [1:0]           data_in,
  input  logic [1:0]           data_valid,
  input  logic                 seg_ready,
  output logic [1:0]           gnt,
  output logic [1:0]           data_ready,
  output logic [1:0]           done,
  output logic [1:0]           err,
  output logic                 tb_in,
  output logic                 wreq_data,
  output logic [TB_SIZE_W-1:0] tb_size_in,
  output logic                 wreq_size
);
  import cb_seg_pkg::*;

  localparam logic [TB_SIZE_W-1:0] CNT_ZERO = {TB_SIZE_W{1'b0}};
  localparam logic [TB_SIZE_W-1:0] CNT_ONE  = {{(TB_SIZE_W-1){1'b0}}, 1'b1};

  ingress_state_t       state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 gsel_q, gsel_d;
  logic [TB_SIZE_W-1:0] cnt_q, cnt_d;

  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           data_ready_q, data_ready_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic                 tb_in_q, tb_in_d;
  logic                 wreq_data_q, wreq_data_d;
  logic                 wreq_size_q, wreq_size_d;
  logic [TB_SIZE_W-1:0] tb_size_q, tb_size_d;

  logic                 arb_en_s;
  logic [1:0]           win_s;
  logic                 win_idx_s;
  logic [TB_SIZE_W-1:0] win_size_s;
  logic                 grant_s;
  logic                 reject_s;
  logic                 accept_s;
  logic                 last_s;

  assign arb_en_s = (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .req (req),
    .rr  (rr_q),
    .adv (arb_en_s),
    .win (win_s)
  );

  // Decode arbitration outcome and data-bit acceptance for this cycle.
  always_comb begin
    win_idx_s  = win_s[1];
    win_size_s = win_s[1] ? size1 : size0;
    reject_s   = (win_s != 2'b00) && (win_size_s == CNT_ZERO);
    grant_s    = (win_s != 2'b00) && (win_size_s != CNT_ZERO) && seg_ready;
    accept_s   = (state_q == DATA) && data_ready_q[gsel_q] && data_valid[gsel_q];
    last_s     = accept_s && (cnt_q == CNT_ONE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = SIZE;
        end else begin
          state_d = IDLE;
        end
      end
      SIZE: state_d = DATA;
      DATA: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-robin pointer, granted-requester select and remaining-bit counter.
  always_comb begin
    rr_d   = rr_q;
    gsel_d = gsel_q;
    cnt_d  = cnt_q;
    if (grant_s || reject_s) begin
      rr_d = ~win_idx_s;
    end else begin
      rr_d = rr_q;
    end
    if (grant_s) begin
      gsel_d = win_idx_s;
      cnt_d  = win_size_s;
    end else if (accept_s && (cnt_q != CNT_ZERO)) begin
      gsel_d = gsel_q;
      cnt_d  = cnt_q - CNT_ONE;
    end else begin
      gsel_d = gsel_q;
      cnt_d  = cnt_q;
    end
  end

  // FSM output logic: next values of every registered output.
  always_comb begin
    gnt_d        = 2'b00;
    data_ready_d = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    tb_in_d      = 1'b0;
    wreq_data_d  = 1'b0;
    wreq_size_d  = 1'b0;
    tb_size_d    = tb_size_q;
    if (state_d != IDLE) begin
      gnt_d = onehot2(gsel_d);
    end else begin
      gnt_d = 2'b00;
    end
    if (state_d == DATA) begin
      data_ready_d = onehot2(gsel_d);
    end else begin
      data_ready_d = 2'b00;
    end
    if (reject_s) begin
      err_d = win_s;
    end else begin
      err_d = 2'b00;
    end
    if (grant_s) begin
      wreq_size_d = 1'b1;
      tb_size_d   = win_size_s;
    end else begin
      wreq_size_d = 1'b0;
      tb_size_d   = tb_size_q;
    end
    if (accept_s) begin
      wreq_data_d = 1'b1;
      tb_in_d     = data_in[gsel_q];
    end else begin
      wreq_data_d = 1'b0;
      tb_in_d     = 1'b0;
    end
    if (last_s) begin
      done_d = onehot2(gsel_q);
    end else begin
      done_d = 2'b00;
    end
  end

  // Datapath and output registers; a reset abandons any partial TB.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q         <= 1'b0;
      gsel_q       <= 1'b0;
      cnt_q        <= CNT_ZERO;
      gnt_q        <= 2'b00;
      data_ready_q <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      tb_in_q      <= 1'b0;
      wreq_data_q  <= 1'b0;
      wreq_size_q  <= 1'b0;
      tb_size_q    <= CNT_ZERO;
    end else begin
      rr_q         <= rr_d;
      gsel_q       <= gsel_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      data_ready_q <= data_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tb_in_q      <= tb_in_d;
      wreq_data_q  <= wreq_data_d;
      wreq_size_q  <= wreq_size_d;
      tb_size_q    <= tb_size_d;
    end
  end

  assign gnt        = gnt_q;
  assign data_ready = data_ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign tb_in      = tb_in_q;
  assign wreq_data  = wreq_data_q;
  assign wreq_size  = wreq_size_q;
  assign tb_size_in = tb_size_q;

endmodule

// File: tb/tb_cb_seg_ingress_arb.sv
// Directed/randomized bench for cb_seg_ingress_arb. Expected write streams
// are built per transport block from the round-robin rule and compared with
// the writes observed at the segmenter side.
module tb_cb_seg_ingress_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] size0, size1;
  logic [1:0]  data_in, data_valid;
  logic        seg_ready;
  logic [1:0]  gnt, data_ready, done, err;
  logic        tb_in, wreq_data, wreq_size;
  logic [15:0] tb_size_in;

  always #5 clk = ~clk;

  cb_seg_ingress_arb #(.TB_SIZE_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .size0(size0), .size1(size1),
    .data_in(data_in), .data_valid(data_valid), .seg_ready(seg_ready),
    .gnt(gnt), .data_ready(data_ready), .done(done), .err(err),
    .tb_in(tb_in), .wreq_data(wreq_data), .tb_size_in(tb_size_in),
    .wreq_size(wreq_size)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int   done_cnt [2];
  int   err_cnt  [2];
  logic bitv [2][0:127];
  int   tb_len [2];
  int   ptr    [2];
  int   vmode  [2];
  int   pidx   [2];
  logic [6:0] vpat = 7'b1011001;
  logic model_rr;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wreq_size === 1'b1) obs_q.push_back(32'h10000 | {16'b0, tb_size_in});
    if (wreq_data === 1'b1) obs_q.push_back({31'b0, tb_in});
    for (int i = 0; i < 2; i++) begin
      if (done[i] === 1'b1) done_cnt[i]++;
      if (err[i] === 1'b1) err_cnt[i]++;
    end
  endtask

  // One clock of requester behaviour for both ports plus per-bit latency checks.
  task automatic step();
    logic [1:0] acc;
    logic [1:0] abit;
    logic       v;
    acc  = data_ready & data_valid;
    abit = data_in;
    tick();
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        check("wdata_lat", {31'b0, wreq_data}, 32'd1);
        check("tb_in_bit", {31'b0, tb_in}, {31'b0, abit[i]});
        ptr[i]++;
        if (ptr[i] == tb_len[i]) begin
          check("done_pulse", {30'b0, done}, (i == 0) ? 32'd1 : 32'd2);
          check("rdy_drop", {31'b0, data_ready[i]}, 32'd0);
        end
      end
      if (gnt[i] === 1'b1 || err[i] === 1'b1) req[i] = 1'b0;
      if (data_ready[i] === 1'b1 && ptr[i] < tb_len[i]) begin
        case (vmode[i])
          0:       v = 1'b1;
          1:       v = ($urandom_range(0, 1) == 1);
          default: begin v = vpat[pidx[i] % 7]; pidx[i]++; end
        endcase
        data_valid[i] = v;
        data_in[i]    = bitv[i][ptr[i]];
      end else begin
        data_valid[i] = ($urandom_range(0, 1) == 1);
        data_in[i]    = ($urandom_range(0, 1) == 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  {30'b0, gnt}, 32'd0);
    check({tag, "_rdy"},  {30'b0, data_ready}, 32'd0);
    check({tag, "_done"}, {30'b0, done}, 32'd0);
    check({tag, "_err"},  {30'b0, err}, 32'd0);
    check({tag, "_tbin"}, {31'b0, tb_in}, 32'd0);
    check({tag, "_wdat"}, {31'b0, wreq_data}, 32'd0);
    check({tag, "_wsz"},  {31'b0, wreq_size}, 32'd0);
    check({tag, "_size"}, {16'b0, tb_size_in}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    req = 2'b00;
    data_valid = 2'b00;
    tick();
    check_all_zero(tag);
    tick();
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; err_cnt[i] = 0; tb_len[i] = 0; ptr[i] = 0;
    end
    model_rr = 1'b0;
  endtask

  task automatic load_tb(input int i, input int len, input int vm);
    tb_len[i] = len; ptr[i] = 0; pidx[i] = 0; vmode[i] = vm;
    for (int k = 0; k < len; k++) bitv[i][k] = ($urandom_range(0, 1) == 1);
    if (i == 0) size0 = 16'(len); else size1 = 16'(len);
  endtask

  task automatic expect_tb(input int i);
    exp_q.push_back(32'h10000 | 32'(tb_len[i]));
    for (int k = 0; k < tb_len[i]; k++) exp_q.push_back({31'b0, bitv[i][k]});
    model_rr = (i == 0) ? 1'b1 : 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int i, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[i] < target && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt[i]), 32'(target));
    step();
    check({tag, "_gnt_low"}, {30'b0, gnt}, 32'd0);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) check(tag, obs_q[k], exp_q[k]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int first;
    logic [4:0] pat5;
    reset = 1'b1; req = 2'b00; size0 = 16'd0; size1 = 16'd0;
    data_in = 2'b00; data_valid = 2'b00; seg_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tb_len[i] = 0; ptr[i] = 0; vmode[i] = 0; pidx[i] = 0;
      done_cnt[i] = 0; err_cnt[i] = 0;
    end

    // Reset state.
    do_reset("rst");

    // Single TB: size 5, bits 1,0,1,1,0 back-to-back.
    load_tb(0, 5, 0);
    pat5 = 5'b01101;
    for (int k = 0; k < 5; k++) bitv[0][k] = pat5[k];
    expect_tb(0);
    req[0] = 1'b1;
    step();
    check("single_gnt_t1", {30'b0, gnt}, 32'd1);
    check("single_wsz_t1", {31'b0, wreq_size}, 32'd1);
    check("single_size_t1", {16'b0, tb_size_in}, 32'd5);
    step();
    check("single_rdy_t2", {30'b0, data_ready}, 32'd1);
    check("single_wsz_t2", {31'b0, wreq_size}, 32'd0);
    run_until_done("single", 0, 1, 40);
    check("single_size_hold", {16'b0, tb_size_in}, 32'd5);
    cmp_stream("single_stream");

    // Contention after reset: two simultaneous pairs, size 3, random valid.
    do_reset("rst2");
    for (int pair = 0; pair < 2; pair++) begin
      load_tb(0, 3, 1);
      load_tb(1, 3, 1);
      first = model_rr ? 1 : 0;
      expect_tb(first);
      expect_tb(1 - first);
      req = 2'b11;
      step();
      check("cont_first_gnt", {30'b0, gnt}, (first == 0) ? 32'd1 : 32'd2);
      run_until_done("cont_a", first, 1 + pair, 60);
      run_until_done("cont_b", 1 - first, 1 + pair, 60);
      check("cont_rr_back_to_0", {31'b0, model_rr}, 32'd0);
    end
    cmp_stream("cont_stream");

    // Valid gaps: size 4, valid pattern 1,0,0,1,1,0,1.
    load_tb(0, 4, 2);
    expect_tb(0);
    req[0] = 1'b1;
    run_until_done("gaps", 0, 3, 40);
    check("gaps_pidx", 32'(pidx[0]), 32'd7);
    cmp_stream("gaps_stream");

    // Backpressure: seg_ready low for 10 cycles holds off requester 1.
    load_tb(1, $urandom_range(1, 8), 1);
    seg_ready = 1'b0;
    req[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_no_grant", {29'b0, gnt, wreq_size}, 32'd0);
    end
    seg_ready = 1'b1;
    expect_tb(1);
    step();
    check("bp_gnt", {30'b0, gnt}, 32'd2);
    check("bp_wsz", {31'b0, wreq_size}, 32'd1);
    run_until_done("bp", 1, 3, 60);
    cmp_stream("bp_stream");

    // Zero size: requester 0 (favoured) rejected, pending requester 1 granted next.
    load_tb(0, 0, 0);
    load_tb(1, 2, 0);
    check("zero_rr_model", {31'b0, model_rr}, 32'd0);
    req = 2'b11;
    step();
    check("zero_err", {30'b0, err}, 32'd1);
    check("zero_no_wsz", {31'b0, wreq_size}, 32'd0);
    check("zero_no_gnt", {30'b0, gnt}, 32'd0);
    expect_tb(1);
    step();
    check("zero_next_gnt", {30'b0, gnt}, 32'd2);
    check("zero_err_pulse", {30'b0, err}, 32'd0);
    run_until_done("zero", 1, 4, 40);
    check("zero_err_cnt", 32'(err_cnt[0]), 32'd1);
    cmp_stream("zero_stream");

    // Reset in the middle of a 100-bit TB, then a fresh 2-bit TB.
    load_tb(0, 100, 0);
    req[0] = 1'b1;
    for (int c = 0; c < 200 && ptr[0] < 40; c++) step();
    check("mid_reached_40", 32'(ptr[0]), 32'd40);
    do_reset("mid_rst");
    load_tb(1, 2, 1);
    expect_tb(1);
    req[1] = 1'b1;
    run_until_done("post_rst", 1, 1, 40);
    cmp_stream("post_rst_stream");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
